// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Moore sequencing FSM for the multicycle RV32I datapath.
//               Optional memory wait states when MEM_WAIT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       funct3_0,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       mem_req,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALWB    = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    state_t r_state;
    state_t w_next;

    logic w_ready;
    logic w_taken;
    logic w_pc_update;
    logic w_pcwrite;
    logic w_memwrite;
    logic w_mem_req;
    logic w_irwrite;
    logic w_regwrite;
    logic w_done;

`ifdef MEM_WAIT_EN
    // Only the three memory-access states can stall; everything else is single-cycle.
    assign w_ready = ((r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                      (r_state == S_MEMWRITE)) ? mem_ready : 1'b1;
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = mem_ready;
    assign w_ready            = 1'b1;
`endif

    assign w_taken = zero ^ funct3_0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (w_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    c_OP_LOAD,
                    c_OP_STORE:  w_next = S_MEMADR;
                    c_OP_RTYPE:  w_next = S_EXECR;
                    c_OP_ITYPE:  w_next = S_EXECI;
                    c_OP_BRANCH: w_next = S_BRANCH;
                    c_OP_JAL:    w_next = S_JAL;
                    c_OP_JALR:   w_next = S_JALR;
                    c_OP_LUI:    w_next = S_LUI;
                    c_OP_AUIPC:  w_next = S_AUIPC;
                    default:     w_next = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (w_ready) w_next = S_MEMWB;
            S_MEMWRITE: if (w_ready) w_next = S_FETCH;
            S_MEMWB,
            S_ALUWB,
            S_JALWB,
            S_BRANCH:   w_next = S_FETCH;
            S_EXECR,
            S_EXECI,
            S_LUI,
            S_AUIPC,
            S_JAL:      w_next = S_ALUWB;
            S_JALR:     w_next = S_JALWB;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_pc_update = 1'b0;
        w_pcwrite   = 1'b0;
        AdrSrc      = 1'b0;
        w_memwrite  = 1'b0;
        w_mem_req   = 1'b0;
        w_irwrite   = 1'b0;
        w_regwrite  = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        w_done      = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_irwrite   = w_ready;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                w_pc_update = 1'b1;
            end
            // ALUOut captures OldPC+imm here so BRANCH/JAL find their target ready.
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc    = 1'b1;
                w_mem_req = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_mem_req  = 1'b1;
                w_memwrite = 1'b1;
                w_done     = w_ready;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            // PC takes the DECODE-computed target while the ALU forms OldPC+4 for rd.
            S_JAL: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
            end
            S_JALR: begin
                ALUSrcA     = 2'b10;
                ALUSrcB     = 2'b01;
                ResultSrc   = 2'b10;
                w_pc_update = 1'b1;
            end
            S_JALWB: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUOp     = 2'b01;
                w_pcwrite = w_taken;
                w_done    = 1'b1;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
    end

    // Strobes are masked directly by reset so nothing reaches the datapath mid-reset.
    assign PCWrite    = ((w_pc_update & w_ready) | w_pcwrite) & ~reset;
    assign MemWrite   = w_memwrite & ~reset;
    assign mem_req    = w_mem_req  & ~reset;
    assign IRWrite    = w_irwrite  & ~reset;
    assign RegWrite   = w_regwrite & ~reset;
    assign instr_done = w_done     & ~reset;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multicycle RV32I core variant: a Moore FSM that steps the shared datapath (one ALU, one unified memory port, instruction register, ALUOut register) through fetch, decode, execute, memory and writeback phases per instruction. It decodes opcode and branch condition itself and drives every datapath select and write strobe. ALU function decode stays in the existing ALU decoder, driven by `ALUOp`. It also handles optional memory wait states and illegal-opcode trapping.

## Interface
- No parameters.
- `clk` in 1 — core clock, rising edge.
- `reset` in 1 — asynchronous, active-high.
- `op` in 7 — instruction register bits [6:0].
- `funct3_0` in 1 — instruction bit 12; 0 = beq, 1 = bne.
- `zero` in 1 — ALU zero flag.
- `mem_ready` in 1 — memory completes the current access this cycle.
- `PCWrite` out 1 — PC load enable.
- `AdrSrc` out 1 — memory address: 0 = PC, 1 = Result.
- `MemWrite` out 1 — memory write request.
- `mem_req` out 1 — memory access in progress.
- `IRWrite` out 1 — loads IR and OldPC.
- `RegWrite` out 1 — register file write enable.
- `ResultSrc` out 2 — 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2 — 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- `ALUSrcB` out 2 — 00 = rs2, 01 = ImmExt, 10 = constant 4.
- `ALUOp` out 2 — 00 = add, 01 = subtract/compare, 10 = funct-decoded.
- `instr_done` out 1 — one-cycle pulse in the final state of each instruction.
- `illegal` out 1 — high while in TRAP.
- `state` out 4 — current state, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, JALWB=12, LUI=13, AUIPC=14, TRAP=15.
- Outputs are decoded from state alone (Moore), except `PCWrite` and the memory-ready gating.
- Any field not listed for a state is 0.

**State actions**
- **FETCH**
  - Asserts AdrSrc=0, mem_req, IRWrite, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, PC update.
  - Next: DECODE.
- **DECODE**
  - Asserts ALUSrcA=01, ALUSrcB=01, ALUOp=00, so ALUOut receives the branch/jal target.
  - Next state by opcode:
    - 0000011 and 0100011 → MEMADR.
    - 0110011 → EXECR.
    - 0010011 → EXECI.
    - 1100011 → BRANCH.
    - 1101111 → JAL.
    - 1100111 → JALR.
    - 0110111 → LUI.
    - 0010111 → AUIPC.
    - Any other opcode → TRAP.
- **MEMADR**
  - Asserts ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - Next: op[5]=0 → MEMREAD; op[5]=1 → MEMWRITE.
- **MEMREAD**: AdrSrc=1, ResultSrc=00, mem_req. Next: MEMWB.
- **MEMWB**: ResultSrc=01, RegWrite, instr_done. Next: FETCH.
- **MEMWRITE**: AdrSrc=1, ResultSrc=00, mem_req, MemWrite, instr_done. Next: FETCH.
- **EXECR**: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- **EXECI**: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- **LUI**: ALUSrcA=11, ALUSrcB=01, ALUOp=00. Next: ALUWB.
- **AUIPC**: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next: ALUWB.
- **ALUWB**: ResultSrc=00, RegWrite, instr_done. Next: FETCH.
- **JAL**
  - Asserts ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PC update (PC ← target).
  - Next: ALUWB, which writes OldPC+4.
- **JALR**
  - Asserts ALUSrcA=10, ALUSrcB=01, ResultSrc=10, PC update.
  - Next: JALWB.
- **JALWB**
  - Asserts ALUSrcA=01, ALUSrcB=10, ResultSrc=10, RegWrite, instr_done.
  - Next: FETCH.
- **BRANCH**
  - Asserts ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, instr_done.
  - Taken when `zero ^ funct3_0` = 1.
  - Next: FETCH.
- **TRAP**
  - All strobes 0; `illegal`=1.
  - Held until reset.

**PCWrite**
- `PCWrite` = (PC update & ready) | (BRANCH & taken).
- ready = `mem_ready` in FETCH, 1 in all other states.

## Timing
- **Reset**
  - `reset` forces state to FETCH asynchronously.
  - While `reset` is high, PCWrite, IRWrite, RegWrite, MemWrite, mem_req and instr_done are forced to 0.
  - Selects take their FETCH values; `illegal`=0; `state`=0.
- **Cycles per instruction** (zero wait): lw 5, sw 4, R/I/lui/auipc 4, jal 4, jalr 4, beq/bne 3.
- **Register-file ordering**
  - rs1/rs2 are sampled into datapath registers in DECODE.
  - JALR with rd==rs1 is therefore correct.
- **Reset mid-instruction**
  - No strobe reaches the datapath after `reset` rises.
  - The first FETCH starts the cycle after `reset` falls.
- **Opcode timing**: opcode is sampled only in DECODE and MEMADR; IR is stable in both.

## Configuration
- **`MEM_WAIT_EN` defined**
  - FETCH, MEMREAD and MEMWRITE hold until `mem_ready`=1.
  - While waiting:
    - `mem_req` and `MemWrite` (in MEMWRITE) stay asserted.
    - `IRWrite`, `PCWrite` and `instr_done` stay 0.
  - When `mem_ready`=1, the strobes assert that cycle and the state advances.
- **`MEM_WAIT_EN` undefined**
  - `mem_ready` is ignored and treated as 1.
  - Every memory state lasts exactly one cycle.

## Test plan
- **Reset during EXECR**: assert `reset` → the same cycle, `state`=0 and all strobes 0. Release → FETCH asserts IRWrite=1, PCWrite=1.
- **add (op=0110011)**: states 0,1,6,8,0. RegWrite=1 only in state 8; ALUOp=10 in state 6. instr_done exactly once.
- **lw then sw**
  - lw: 0,1,2,3,4, with ResultSrc=01 in state 4.
  - sw: 0,1,2,5, with MemWrite=1 and AdrSrc=1 for exactly one cycle.
- **Branches**
  - beq with zero=1, funct3_0=0 → PCWrite=1 in BRANCH.
  - bne with zero=1 → PCWrite=0.
  - Both take 3 cycles.
- **Illegal opcode 1111111** → TRAP (15), `illegal`=1, no strobes for 10 cycles; reset recovers to FETCH.
- **With `MEM_WAIT_EN`, mem_ready low for 3 cycles in FETCH** → state stays 0, IRWrite=0, then IRWrite=PCWrite=1 on the ready cycle. Same check for MEMWRITE: MemWrite held 4 cycles.
